// File: rtl/tx_token_pkg.sv
// Shared types, symbol constants and STP field helpers for the TX framing-token packer.
package tx_token_pkg;

  typedef enum logic [1:0] {
    TOK_IDL = 2'd0,
    TOK_SDP = 2'd1,
    TOK_STP = 2'd2,
    TOK_EDS = 2'd3
  } tok_type_t;

  localparam logic [7:0] IDL_SYM  = 8'h00;
  localparam logic [7:0] SDP_SYM0 = 8'hF0;
  localparam logic [7:0] SDP_SYM1 = 8'hAC;
  localparam logic [7:0] EDS_SYM0 = 8'h1F;
  localparam logic [7:0] EDS_SYM1 = 8'h80;
  localparam logic [7:0] EDS_SYM2 = 8'h90;
  localparam logic [7:0] EDS_SYM3 = 8'h00;
  localparam logic [3:0] STP_H    = 4'hF;

  localparam int MAX_TOK_LEN = 4;
  localparam int SYM_CNT_W   = $clog2(MAX_TOK_LEN) + 1;

  // Number of symbols a token occupies on the wire.
  function automatic logic [2:0] tok_len(input tok_type_t t);
    logic [2:0] n;
    case (t)
      TOK_IDL: n = 3'd1;
      TOK_SDP: n = 3'd2;
      TOK_STP: n = 3'd4;
      TOK_EDS: n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // 4-bit check code protecting the 11-bit STP length field.
  function automatic logic [3:0] stp_crc(input logic [10:0] l);
    logic [3:0] c;
    c[0] = l[0] ^ l[1] ^ l[2] ^ l[4] ^ l[6] ^ l[7] ^ l[10];
    c[1] = l[2] ^ l[3] ^ l[4] ^ l[5] ^ l[7] ^ l[9] ^ l[10];
    c[2] = l[1] ^ l[2] ^ l[3] ^ l[4] ^ l[6] ^ l[8] ^ l[9];
    c[3] = l[0] ^ l[1] ^ l[2] ^ l[3] ^ l[5] ^ l[7] ^ l[8];
    return c;
  endfunction

  // Even parity over length and check code together.
  function automatic logic stp_parity(input logic [10:0] l, input logic [3:0] c);
    return (^l) ^ (^c);
  endfunction

endpackage

// File: rtl/stp_field_gen.sv
// Combinational STP symbol former: length adjust, check code, parity and sequence packing.
module stp_field_gen
  import tx_token_pkg::*;
(
  input  logic [10:0]     length,
  input  logic [11:0]     seq,
  output logic [3:0][7:0] stp_sym
);

  logic [10:0] l_s;
  logic [3:0]  c_s;
  logic        p_s;

  // Length field counts the framing overhead, wrapping at 11 bits.
  assign l_s = length + 11'd2;
  assign c_s = stp_crc(l_s);
  assign p_s = stp_parity(l_s, c_s);

  assign stp_sym[0] = {l_s[3:0], STP_H};
  assign stp_sym[1] = {p_s, l_s[10:4]};
  assign stp_sym[2] = {c_s, seq[11:8]};
  assign stp_sym[3] = seq[7:0];

endmodule

// File: rtl/token_stream_packer.sv
// Framing-token packer: accepts STP/SDP/EDS/IDL requests and serialises their symbols
// onto a LANES-wide beat stream with downstream backpressure.
// Optional build macro TOKEN_SEQ_AUTO_EN: STP sequence numbers come from an internal
// 12-bit counter instead of i_seq_num.
module token_stream_packer
  import tx_token_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int SYMBOL_WIDTH  = 8,
  parameter int SEQ_NUM_WIDTH = 12,
  parameter int PACKET_LENGTH = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_tok_valid,
  output logic                      o_tok_ready,
  input  logic [1:0]                i_tok_type,
  input  logic [PACKET_LENGTH-1:0]  i_length,
  input  logic [SEQ_NUM_WIDTH-1:0]  i_seq_num,
  output logic [LANES*SYMBOL_WIDTH-1:0] o_sym_data,
  output logic                      o_sym_valid,
  output logic [LANES-1:0]          o_sym_is_tok,
  input  logic                      i_out_ready
);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t                      state_r, state_nx_s;
  logic [SYM_CNT_W-1:0]        sym_cnt_r, sym_cnt_nx_s, src_off_s;
  logic [3:0][7:0]             tok_sym_r, req_sym_s, stp_sym_s, src_sym_s;
  logic [2:0]                  tok_len_r, req_len_s, src_len_s;
  tok_type_t                   req_type_s;
  logic [SEQ_NUM_WIDTH-1:0]    seq_sel_s;
  logic                        last_beat_s, tok_ready_s, tok_fire_s;
  logic                        load_beat_s, use_req_s, valid_nx_s;
  logic [LANES*SYMBOL_WIDTH-1:0] beat_data_s;
  logic [LANES-1:0]            beat_tok_s;

  assign req_type_s  = tok_type_t'(i_tok_type);
  assign o_tok_ready = i_rst_n & tok_ready_s;
  assign tok_fire_s  = i_tok_valid & o_tok_ready;

`ifdef TOKEN_SEQ_AUTO_EN
  logic [SEQ_NUM_WIDTH-1:0] seq_cnt_r;
  logic                     unused_seq_s;

  assign unused_seq_s = ^i_seq_num;
  assign seq_sel_s    = seq_cnt_r;

  // Auto sequence counter: advances once per accepted STP, wrapping naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      seq_cnt_r <= 12'd0;
    end else if (tok_fire_s && (req_type_s == TOK_STP)) begin
      seq_cnt_r <= seq_cnt_r + 12'd1;
    end
  end
`else
  assign seq_sel_s = i_seq_num;
`endif

  stp_field_gen u_stp_field_gen (
    .length  (i_length[10:0]),
    .seq     (seq_sel_s[11:0]),
    .stp_sym (stp_sym_s)
  );

  // Symbol list of the request currently on the input port.
  always_comb begin
    req_sym_s = '0;
    req_len_s = tok_len(req_type_s);
    case (req_type_s)
      TOK_IDL: req_sym_s[0] = IDL_SYM;
      TOK_SDP: begin
        req_sym_s[0] = SDP_SYM0;
        req_sym_s[1] = SDP_SYM1;
      end
      TOK_EDS: begin
        req_sym_s[0] = EDS_SYM0;
        req_sym_s[1] = EDS_SYM1;
        req_sym_s[2] = EDS_SYM2;
        req_sym_s[3] = EDS_SYM3;
      end
      TOK_STP: req_sym_s = stp_sym_s;
      default: req_sym_s = '0;
    endcase
  end

  // The beat on the output is the last one when it covers all remaining symbols.
  assign last_beat_s = (int'(sym_cnt_r) + LANES) >= int'(tok_len_r);

  // Next-state, handshake and beat-load decisions.
  always_comb begin
    state_nx_s   = state_r;
    sym_cnt_nx_s = sym_cnt_r;
    valid_nx_s   = o_sym_valid;
    load_beat_s  = 1'b0;
    use_req_s    = 1'b0;
    tok_ready_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        tok_ready_s  = 1'b1;
        sym_cnt_nx_s = '0;
        if (i_tok_valid) begin
          state_nx_s  = S_EMIT;
          valid_nx_s  = 1'b1;
          load_beat_s = 1'b1;
          use_req_s   = 1'b1;
        end else begin
          valid_nx_s  = 1'b0;
        end
      end
      S_EMIT: begin
        if (i_out_ready) begin
          if (last_beat_s) begin
            tok_ready_s  = 1'b1;
            sym_cnt_nx_s = '0;
            if (i_tok_valid) begin
              load_beat_s = 1'b1;
              use_req_s   = 1'b1;
            end else begin
              state_nx_s  = S_IDLE;
              valid_nx_s  = 1'b0;
            end
          end else begin
            sym_cnt_nx_s = sym_cnt_r + SYM_CNT_W'(LANES);
            load_beat_s  = 1'b1;
          end
        end else begin
          sym_cnt_nx_s = sym_cnt_r;
        end
      end
      default: begin
        state_nx_s   = S_IDLE;
        sym_cnt_nx_s = '0;
        valid_nx_s   = 1'b0;
      end
    endcase
  end

  assign src_sym_s = use_req_s ? req_sym_s : tok_sym_r;
  assign src_len_s = use_req_s ? req_len_s : tok_len_r;
  assign src_off_s = use_req_s ? '0 : sym_cnt_nx_s;

  // Lane muxing: place symbols starting at lane 0, IDL-fill the unused lanes.
  always_comb begin
    beat_data_s = '0;
    beat_tok_s  = '0;
    for (int k = 0; k < LANES; k++) begin
      int idx;
      idx = int'(src_off_s) + k;
      if (idx < int'(src_len_s)) begin
        beat_data_s[k*SYMBOL_WIDTH +: SYMBOL_WIDTH] = SYMBOL_WIDTH'(src_sym_s[idx[1:0]]);
        beat_tok_s[k] = 1'b1;
      end else begin
        beat_tok_s[k] = 1'b0;
      end
    end
  end

  // State, counter, token capture and registered beat outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= S_IDLE;
      sym_cnt_r    <= '0;
      tok_sym_r    <= '0;
      tok_len_r    <= 3'd0;
      o_sym_valid  <= 1'b0;
      o_sym_data   <= '0;
      o_sym_is_tok <= '0;
    end else begin
      state_r     <= state_nx_s;
      sym_cnt_r   <= sym_cnt_nx_s;
      o_sym_valid <= valid_nx_s;
      if (tok_fire_s) begin
        tok_sym_r <= req_sym_s;
        tok_len_r <= req_len_s;
      end
      if (load_beat_s) begin
        o_sym_data   <= beat_data_s;
        o_sym_is_tok <= beat_tok_s;
      end else if (!valid_nx_s) begin
        o_sym_data   <= '0;
        o_sym_is_tok <= '0;
      end
    end
  end

endmodule

// File: tb/tb_token_stream_packer.sv
// Self-checking bench: three packers (1, 2 and 4 lanes) driven with directed and
// random token requests, compared every cycle against a queue-based beat model.
module tb_token_stream_packer;

  localparam int NI = 3;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tok;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_n     [NI];
  logic        tok_valid [NI];
  logic        out_ready [NI];
  logic        tok_ready [NI];
  logic        sym_valid [NI];
  logic [1:0]  tok_type  [NI];
  logic [10:0] length    [NI];
  logic [11:0] seq_num   [NI];
  logic [31:0] sd        [NI];
  logic [3:0]  st        [NI];

  logic [7:0]  d0;
  logic [15:0] d1;
  logic [31:0] d2;
  logic [0:0]  t0;
  logic [1:0]  t1;
  logic [3:0]  t2;

  assign sd[0] = {24'd0, d0};
  assign sd[1] = {16'd0, d1};
  assign sd[2] = d2;
  assign st[0] = {3'd0, t0};
  assign st[1] = {2'd0, t1};
  assign st[2] = t2;

  beat_t exp_q [NI][$];
  bit    acc_flag [NI];
  bit    rst_prev [NI];
  bit    done     [NI];
  bit    rdy_mode [NI];
  int    seq_model[NI];

  token_stream_packer #(.LANES(1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_tok_valid(tok_valid[0]), .o_tok_ready(tok_ready[0]),
    .i_tok_type(tok_type[0]), .i_length(length[0]), .i_seq_num(seq_num[0]),
    .o_sym_data(d0), .o_sym_valid(sym_valid[0]), .o_sym_is_tok(t0), .i_out_ready(out_ready[0]));

  token_stream_packer #(.LANES(2)) u1 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_tok_valid(tok_valid[1]), .o_tok_ready(tok_ready[1]),
    .i_tok_type(tok_type[1]), .i_length(length[1]), .i_seq_num(seq_num[1]),
    .o_sym_data(d1), .o_sym_valid(sym_valid[1]), .o_sym_is_tok(t1), .i_out_ready(out_ready[1]));

  token_stream_packer #(.LANES(4)) u2 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_tok_valid(tok_valid[2]), .o_tok_ready(tok_ready[2]),
    .i_tok_type(tok_type[2]), .i_length(length[2]), .i_seq_num(seq_num[2]),
    .o_sym_data(d2), .o_sym_valid(sym_valid[2]), .o_sym_is_tok(t2), .i_out_ready(out_ready[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Token symbols straight from the framing rules.
  function automatic void tok_syms(input int ty, input int len, input int seq,
                                   output int n, output int s[4]);
    int lst [4][7];
    int l, c, p;
    lst = '{'{0,1,2,4,6,7,10}, '{2,3,4,5,7,9,10}, '{1,2,3,4,6,8,9}, '{0,1,2,3,5,7,8}};
    s = '{0, 0, 0, 0};
    case (ty)
      0: n = 1;
      1: begin n = 2; s[0] = 'hF0; s[1] = 'hAC; end
      3: begin n = 4; s[0] = 'h1F; s[1] = 'h80; s[2] = 'h90; s[3] = 'h00; end
      default: begin
        n = 4;
        l = (len + 2) % 2048;
        c = 0;
        for (int j = 0; j < 4; j++)
          for (int m = 0; m < 7; m++)
            c = c ^ (((l >> lst[j][m]) & 1) << j);
        p = ($countones(l) + $countones(c)) % 2;
        s[0] = ((l & 15) << 4) | 15;
        s[1] = (p << 7) | (l >> 4);
        s[2] = (c << 4) | ((seq >> 8) & 15);
        s[3] = seq & 255;
      end
    endcase
  endfunction

  function automatic logic [31:0] pack4(input int s[4]);
    return {8'(s[0]), 8'(s[1]), 8'(s[2]), 8'(s[3])};
  endfunction

  // Split a token into beats of 'lanes' symbols, lane 0 first.
  function automatic void push_token(input int i, input int ty, input int len, input int seq);
    int n, lanes, nb;
    int s[4];
    beat_t b;
    lanes = 1 << i;
    tok_syms(ty, len, seq, n, s);
    nb = (n + lanes - 1) / lanes;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int k = 0; k < lanes; k++) begin
        if (bi * lanes + k < n) begin
          b.data = b.data | (32'(s[bi * lanes + k]) << (8 * k));
          b.tok  = b.tok | (4'd1 << k);
        end
      end
      b.last = (bi == nb - 1);
      exp_q[i].push_back(b);
    end
  endfunction

  // Compare process: every cycle, every instance, against the model queue.
  always @(negedge clk) begin
    beat_t e;
    int sq;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n[i]) begin
        chk("reset_tok_ready", 64'(tok_ready[i]), 64'd0);
        if (rst_prev[i] == 1'b0) begin
          chk("reset_valid", 64'(sym_valid[i]), 64'd0);
          chk("reset_data", 64'(sd[i]), 64'd0);
          chk("reset_is_tok", 64'(st[i]), 64'd0);
        end
        exp_q[i].delete();
        seq_model[i] = 0;
      end else begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i][0];
          chk("beat_valid", 64'(sym_valid[i]), 64'd1);
          chk("beat_data", 64'(sd[i]), 64'(e.data));
          chk("beat_is_tok", 64'(st[i]), 64'(e.tok));
          chk("emit_tok_ready", 64'(tok_ready[i]), 64'(e.last & out_ready[i]));
          if (out_ready[i]) exp_q[i].pop_front();
        end else begin
          chk("idle_valid", 64'(sym_valid[i]), 64'd0);
          chk("idle_data", 64'(sd[i]), 64'd0);
          chk("idle_is_tok", 64'(st[i]), 64'd0);
          chk("idle_tok_ready", 64'(tok_ready[i]), 64'd1);
        end
        if (tok_valid[i] && tok_ready[i]) begin
          acc_flag[i] = 1'b1;
`ifdef TOKEN_SEQ_AUTO_EN
          sq = seq_model[i];
          if (tok_type[i] == 2'd2) seq_model[i] = (seq_model[i] + 1) % 4096;
`else
          sq = int'(seq_num[i]);
`endif
          push_token(i, int'(tok_type[i]), int'(length[i]), sq);
        end
      end
      rst_prev[i] = rst_n[i];
    end
  end

  task automatic set_ready(input int i);
    out_ready[i] = rdy_mode[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  task automatic step(input int i, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      set_ready(i);
    end
  endtask

  // Offer one request and wait (bounded) until it is accepted, then scramble the inputs.
  task automatic send(input int i, input int ty, input int len, input int seq);
    int cyc;
    cyc = 0;
    acc_flag[i]  = 1'b0;
    tok_valid[i] = 1'b1;
    tok_type[i]  = 2'(ty);
    length[i]    = 11'(len);
    seq_num[i]   = 12'(seq);
    do begin
      @(posedge clk); #1;
      set_ready(i);
      cyc++;
    end while (!acc_flag[i] && cyc < 200);
    if (!acc_flag[i]) chk("accept_timeout", 64'd0, 64'd1);
    acc_flag[i]  = 1'b0;
    tok_valid[i] = 1'b0;
    tok_type[i]  = 2'($urandom_range(0, 3));
    length[i]    = 11'($urandom_range(0, 2047));
    seq_num[i]   = 12'($urandom_range(0, 4095));
  endtask

  task automatic drain(input int i);
    int cyc;
    cyc = 0;
    rdy_mode[i] = 1'b0;
    while (exp_q[i].size() > 0 && cyc < 100) begin
      step(i, 1);
      cyc++;
    end
    chk("drain_empty", 64'(exp_q[i].size()), 64'd0);
  endtask

  task automatic random_run(input int i, input int n);
    rdy_mode[i] = 1'b1;
    for (int t = 0; t < n; t++) begin
      send(i, $urandom_range(0, 3), $urandom_range(0, 2047), $urandom_range(0, 4095));
      if ($urandom_range(0, 2) == 0) step(i, $urandom_range(1, 3));
    end
    drain(i);
  endtask

  task automatic init_inst(input int i);
    rst_n[i] = 1'b0; tok_valid[i] = 1'b0; out_ready[i] = 1'b1;
    tok_type[i] = 2'd0; length[i] = 11'd0; seq_num[i] = 12'd0;
    rdy_mode[i] = 1'b0; acc_flag[i] = 1'b0; rst_prev[i] = 1'b0; done[i] = 1'b0;
    seq_model[i] = 0;
  endtask

  // Model pins: hand-computed STP symbol words.
  initial begin
    int n;
    int s[4];
    // len 4 -> L=6, C=0x2, P = ^L ^ ^C = 0 ^ 1 = 1
    tok_syms(2, 4, 'h123, n, s);
    chk("pin_stp_len4", 64'(pack4(s)), 64'h6F802123);
    // len 0x7FE -> L wraps to 0, C=0, P=0
    tok_syms(2, 2046, 'hABC, n, s);
    chk("pin_stp_wrap", 64'(pack4(s)), 64'h0F000ABC);
    // len 0x7FF -> L=1, C=0x9, P=1
    tok_syms(2, 2047, 'h000, n, s);
    chk("pin_stp_l1", 64'(pack4(s)), 64'h1F809000);
  end

  // LANES=1: STP stalled mid-token, then random traffic.
  initial begin
    init_inst(0);
    step(0, 3);
    rst_n[0] = 1'b1;
    step(0, 1);
    send(0, 2, 'h004, 'h123);
    step(0, 1);
    out_ready[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready[0] = 1'b1;
    drain(0);
    random_run(0, 120);
    done[0] = 1'b1;
  end

  // LANES=2: SDP+EDS back-to-back, reset during EDS beat 1, clean SDP after.
  initial begin
    init_inst(1);
    step(1, 3);
    rst_n[1] = 1'b1;
    step(1, 1);
    send(1, 1, 0, 0);
    send(1, 3, 0, 0);
    drain(1);
    send(1, 3, 0, 0);
    step(1, 1);
    rst_n[1] = 1'b0;
    step(1, 2);
    rst_n[1] = 1'b1;
    send(1, 1, 0, 0);
    drain(1);
    random_run(1, 120);
    done[1] = 1'b1;
  end

  // LANES=4: STP/IDL/SDP directed, optional auto-sequence sweep, random traffic.
  initial begin
    init_inst(2);
    step(2, 3);
    rst_n[2] = 1'b1;
    step(2, 1);
    send(2, 2, 'h004, 'h123);
    send(2, 0, 0, 0);
    send(2, 1, 0, 0);
    drain(2);
`ifdef TOKEN_SEQ_AUTO_EN
    rst_n[2] = 1'b0;
    step(2, 2);
    rst_n[2] = 1'b1;
    step(2, 1);
    for (int t = 0; t < 4097; t++) send(2, 2, $urandom_range(0, 2047), $urandom_range(0, 4095));
    drain(2);
`endif
    random_run(2, 120);
    done[2] = 1'b1;
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 90000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(done[0] && done[1] && done[2])) chk("run_timeout", 64'd0, 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
